// File: rtl/shift_reg_sequencer.sv
// Command-driven sequencer for an external 8-bit load/shift-left/shift-right register.
// Optional early termination on an all-zero register: define SHIFT_SEQ_EARLY_STOP_EN.
module shift_reg_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_early,
    output logic             busy,
    output logic [7:0]       sr_i,
    output logic             sr_load_enable,
    output logic             sr_shift_left_right,
    input  logic [7:0]       sr_q
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, RESP} state_t;

    state_t           r_state;
    logic [7:0]       r_data;
    logic             r_dir;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_rem;
    logic             r_early;
    logic             w_accept;
    logic             w_stop_early;

    assign w_accept = cmd_valid && cmd_ready;

`ifdef SHIFT_SEQ_EARLY_STOP_EN
    // Once the register has zero-filled, further shifts cannot change it.
    assign w_stop_early = (r_state == SHIFT) && (sr_q == 8'h00);
`else
    assign w_stop_early = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_early <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) r_state <= LOAD;
                end
                LOAD: begin
                    if (r_count == '0) begin
                        r_state <= RESP;
                    end else begin
                        r_rem   <= r_count;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_stop_early) begin
                        r_early <= 1'b1;
                        r_state <= RESP;
                    end else begin
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == CNT_W'(1)) r_state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_early <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Command fields are plain data; they are only meaningful after an accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data  <= cmd_data;
            r_dir   <= cmd_dir;
            r_count <= cmd_count;
        end
    end

    // The register has no hold mode, so holding means reloading its own output.
    always_comb begin
        sr_load_enable      = 1'b0;
        sr_i                = sr_q;
        sr_shift_left_right = 1'b0;
        case (r_state)
            LOAD: sr_i = r_data;
            SHIFT: begin
                if (!w_stop_early) begin
                    sr_load_enable      = 1'b1;
                    sr_shift_left_right = r_dir;
                end
            end
            default: ;
        endcase
    end

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_data  = sr_q;
    assign rsp_early = r_early;

endmodule
